pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register that replaces fixed per-stage flops (IF/ID, ID/EX, EX/MEM) with one reusable block. It carries a control bundle, a data bundle and the instruction word across a stage boundary using a valid/ready handshake, with a two-entry skid buffer so upstream ready never depends combinationally on downstream ready. It supports a flush that injects a NOP bubble, and keeps a saturating stall-cycle counter for performance analysis.

## Interface
- CTRL_W, 16, control bundle width (pc_sel, rd_wren, alu_op, wb_sel, lsu_op, ...)
- DATA_W, 128, data bundle width (rs1/rs2 data, immediate, pc, pc+4)
- INSTR_W, 32, instruction word width
- NOP_INSTR, 32'h0000_0013, instruction value loaded on reset, flush or drain (addi x0,x0,0)
- CNT_W, 16, stall counter width
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_flush  in  1  kill all held entries this edge
- i_valid  in  1  upstream payload valid
- o_ready  out  1  block can accept; decoded from registered state only
- i_ctrl  in  CTRL_W  upstream control bundle
- i_data  in  DATA_W  upstream data bundle
- i_instr  in  INSTR_W  upstream instruction
- o_valid  out  1  downstream payload valid
- i_ready  in  1  downstream accepts
- o_ctrl  out  CTRL_W  registered control bundle
- o_data  out  DATA_W  registered data bundle
- o_instr  out  INSTR_W  registered instruction
- o_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0, saturating

## Operation
- Storage: main entry (drives outputs) and skid entry; each holds ctrl, data, instr and a valid bit.
- States: EMPTY (no entries), BUSY (main only), FULL (main + skid).
- in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
- o_ready = 1 in EMPTY and BUSY, 0 in FULL. o_valid = 1 in BUSY and FULL.
- EMPTY: in_fire -> load main, go BUSY.
- BUSY: in_fire & out_fire -> load main, stay BUSY; in_fire & !out_fire -> load skid, go FULL; !in_fire & out_fire -> drain main, go EMPTY; neither -> hold.
- FULL: out_fire -> main <= skid, go BUSY; else hold. No input is accepted.
- Drained or empty main: ctrl = 0, data = 0, instr = NOP_INSTR. Downstream that ignores o_valid therefore sees a harmless NOP with all write enables low.
- Flush: i_flush=1 -> both entries invalidated, main payload loaded with ctrl 0, data 0, NOP_INSTR, go EMPTY. Any i_valid in that cycle is discarded, even though o_ready is 1. Stall counter is unaffected.
- Priority: i_reset > i_flush > handshake.
- Stall counter: increments each edge where o_valid=1 and i_ready=0 and not flushing. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Payload is never modified in place. Held entries are bit-exact while stalled.

## Timing
- Reset values: o_valid 0, o_ready 1 (state EMPTY), o_ctrl 0, o_data 0, o_instr NOP_INSTR, o_stall_cnt 0. The skid entry is invalid.
- Latency: payload accepted on edge N appears on the outputs after edge N, so it is visible in cycle N+1.
- Throughput: one transfer per cycle when i_ready is held at 1. The skid entry is never used in that case.
- o_ready falls the cycle after the skid entry fills and rises the cycle after the skid entry moves into main.
- Ordering is strict FIFO; no entry is lost or duplicated.
- Reset or flush mid-stall (FULL): both entries are dropped at that edge. The next cycle shows o_valid 0 and o_ready 1.
- Reset and flush asserted together: reset behaviour applies, including clearing the counter.

## Test plan
- Reset: hold i_reset for 2 cycles with i_valid=1 -> o_valid 0, o_ready 1, o_instr 32'h0000_0013, o_stall_cnt 0.
- Streaming: i_ready=1, push instr 0x00A00093, 0x00B00113, 0x00C00193 on consecutive cycles -> same values appear one cycle later on consecutive cycles; o_ready stays 1; o_stall_cnt stays 0.
- Skid fill: i_ready=0, push A=0x11, B=0x22 -> o_ready 0 after the second edge. Release i_ready -> A, then B, on consecutive cycles; o_ready returns to 1; o_stall_cnt equals the number of stalled cycles.
- Flush while FULL: state FULL with A,B held, pulse i_flush with i_valid=1 carrying C -> next cycle o_valid 0, o_ctrl 0, o_instr NOP_INSTR; A, B and C are never output.
- Counter saturation: CNT_W=4, stall 20 cycles with o_valid=1 -> o_stall_cnt reaches 15 and holds at 15.
- Random handshake: random i_valid, i_ready and rare i_flush for 10k cycles against a scoreboard queue -> outputs in order, no loss or duplication except flush-dropped entries, and o_ready never combinationally follows i_ready.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register with a valid/ready handshake and a two-entry skid buffer.
// It supports a flush that injects a NOP bubble and keeps a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int               CTRL_W    = 16,
    parameter int               DATA_W    = 128,
    parameter int               INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int               CNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [CTRL_W-1:0]  i_ctrl,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [CTRL_W-1:0]  o_ctrl,
    output logic [DATA_W-1:0]  o_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic [CNT_W-1:0]   o_stall_cnt
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_fire, out_fire;

    // Both handshake outputs decode from state only, so upstream ready never sees i_ready.
    assign o_ready     = (state_q != S_FULL);
    assign o_valid     = (state_q != S_EMPTY);
    assign o_ctrl      = main_ctrl_q;
    assign o_data      = main_data_q;
    assign o_instr     = main_instr_q;
    assign o_stall_cnt = cnt_q;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        state_d      = state_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        main_instr_d = main_instr_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_instr_d = skid_instr_q;
        if (i_flush) begin
            state_d      = S_EMPTY;
            main_ctrl_d  = '0;
            main_data_d  = '0;
            main_instr_d = NOP_INSTR;
            skid_ctrl_d  = '0;
            skid_data_d  = '0;
            skid_instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d      = S_BUSY;
                        main_ctrl_d  = i_ctrl;
                        main_data_d  = i_data;
                        main_instr_d = i_instr;
                    end
                end
                S_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d  = i_ctrl;
                        main_data_d  = i_data;
                        main_instr_d = i_instr;
                    end else if (in_fire) begin
                        state_d      = S_FULL;
                        skid_ctrl_d  = i_ctrl;
                        skid_data_d  = i_data;
                        skid_instr_d = i_instr;
                    end else if (out_fire) begin
                        // Drained main shows a harmless NOP with all enables low.
                        state_d      = S_EMPTY;
                        main_ctrl_d  = '0;
                        main_data_d  = '0;
                        main_instr_d = NOP_INSTR;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_d      = S_BUSY;
                        main_ctrl_d  = skid_ctrl_q;
                        main_data_d  = skid_data_q;
                        main_instr_d = skid_instr_q;
                        skid_ctrl_d  = '0;
                        skid_data_d  = '0;
                        skid_instr_d = NOP_INSTR;
                    end
                end
                default: begin
                    state_d      = S_EMPTY;
                    main_ctrl_d  = '0;
                    main_data_d  = '0;
                    main_instr_d = NOP_INSTR;
                    skid_ctrl_d  = '0;
                    skid_data_d  = '0;
                    skid_instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!i_flush && o_valid && !i_ready && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_EMPTY;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_instr_q <= NOP_INSTR;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_instr_q <= NOP_INSTR;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            main_instr_q <= main_instr_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_instr_q <= skid_instr_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a two-deep FIFO queue model checked every cycle, plus directed literal checks.
module tb_pipe_stage_reg;

    localparam int CTRL_W  = 16;
    localparam int DATA_W  = 128;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               rst, flush, vld_i, rdy_o, vld_o, rdy_i;
    logic [CTRL_W-1:0]  ctrl_i, ctrl_o;
    logic [DATA_W-1:0]  data_i, data_o;
    logic [INSTR_W-1:0] instr_i, instr_o;
    logic [CNT_W-1:0]   cnt_o;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W),
        .NOP_INSTR(NOP), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_flush(flush),
        .i_valid(vld_i), .o_ready(rdy_o),
        .i_ctrl(ctrl_i), .i_data(data_i), .i_instr(instr_i),
        .o_valid(vld_o), .i_ready(rdy_i),
        .o_ctrl(ctrl_o), .o_data(data_o), .o_instr(instr_o),
        .o_stall_cnt(cnt_o)
    );

    typedef struct packed {
        logic [CTRL_W-1:0]  ctrl;
        logic [DATA_W-1:0]  data;
        logic [INSTR_W-1:0] instr;
    } pay_t;

    pay_t q[$];
    int   m_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   model_on = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Model: a FIFO of at most two entries; ready while it has room, valid while non-empty.
    always @(posedge clk) begin
        bit infire, outfire;
        infire  = vld_i && (q.size() < 2) && !flush;
        outfire = (q.size() > 0) && rdy_i;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !rdy_i && m_cnt < 15) m_cnt++;
            if (outfire) void'(q.pop_front());
            if (infire) q.push_back('{ctrl: ctrl_i, data: data_i, instr: instr_i});
        end
        model_on = 1'b1;
    end

    // Runs after inputs have changed mid-cycle, so any combinational input->output path shows up.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_valid", DATA_W'(vld_o), DATA_W'(q.size() > 0));
            chk("m_ready", DATA_W'(rdy_o), DATA_W'(q.size() < 2));
            chk("m_cnt",   DATA_W'(cnt_o), DATA_W'(m_cnt));
            if (q.size() > 0) begin
                chk("m_ctrl",  DATA_W'(ctrl_o),  DATA_W'(q[0].ctrl));
                chk("m_data",  data_o,           q[0].data);
                chk("m_instr", DATA_W'(instr_o), DATA_W'(q[0].instr));
            end else begin
                chk("m_ctrl_idle",  DATA_W'(ctrl_o),  '0);
                chk("m_data_idle",  data_o,           '0);
                chk("m_instr_idle", DATA_W'(instr_o), DATA_W'(NOP));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [INSTR_W-1:0] ins);
        vld_i   = 1'b1;
        instr_i = ins;
        ctrl_i  = CTRL_W'(ins[15:0] ^ 16'h5a5a);
        data_i  = {4{ins}};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rdy_i = 1'b0;
        push(32'hdead_beef);
        tick(); tick();
        chk("rst_valid", DATA_W'(vld_o), 0);
        chk("rst_ready", DATA_W'(rdy_o), 1);
        chk("rst_instr", DATA_W'(instr_o), DATA_W'(32'h0000_0013));
        chk("rst_cnt",   DATA_W'(cnt_o), 0);
        rst = 1'b0; vld_i = 1'b0;

        // Streaming with i_ready held high
        rdy_i = 1'b1;
        push(32'h00A0_0093); tick();
        chk("str0", DATA_W'(instr_o), DATA_W'(32'h00A0_0093));
        push(32'h00B0_0113); tick();
        chk("str1", DATA_W'(instr_o), DATA_W'(32'h00B0_0113));
        chk("str1_ctrl", DATA_W'(ctrl_o), DATA_W'(16'h0113 ^ 16'h5a5a));
        push(32'h00C0_0193); tick();
        chk("str2", DATA_W'(instr_o), DATA_W'(32'h00C0_0193));
        chk("str_rdy", DATA_W'(rdy_o), 1);
        vld_i = 1'b0; tick();
        chk("str_drain", DATA_W'(vld_o), 0);
        chk("str_cnt", DATA_W'(cnt_o), 0);

        // Skid fill, one extra stall, then release
        rdy_i = 1'b0;
        push(32'h11); tick();
        push(32'h22); tick();
        chk("skid_rdy0", DATA_W'(rdy_o), 0);
        chk("skid_cnt1", DATA_W'(cnt_o), 1);
        vld_i = 1'b0; tick();
        chk("skid_hold", DATA_W'(instr_o), DATA_W'(32'h11));
        rdy_i = 1'b1; tick();
        chk("skid_B", DATA_W'(instr_o), DATA_W'(32'h22));
        chk("skid_rdy1", DATA_W'(rdy_o), 1);
        chk("skid_cnt2", DATA_W'(cnt_o), 2);
        tick();
        chk("skid_empty", DATA_W'(vld_o), 0);

        // Flush while FULL, with C offered in the flush cycle
        rdy_i = 1'b0;
        push(32'h33); tick();
        push(32'h44); tick();
        flush = 1'b1; push(32'h55); tick();
        chk("fl_valid", DATA_W'(vld_o), 0);
        chk("fl_ready", DATA_W'(rdy_o), 1);
        chk("fl_ctrl",  DATA_W'(ctrl_o), 0);
        chk("fl_instr", DATA_W'(instr_o), DATA_W'(NOP));
        chk("fl_cnt",   DATA_W'(cnt_o), 3);
        flush = 1'b0; vld_i = 1'b0; rdy_i = 1'b1; tick();
        chk("fl_after", DATA_W'(vld_o), 0);

        // Saturation
        rdy_i = 1'b0;
        push(32'h66); tick();
        vld_i = 1'b0;
        repeat (20) tick();
        chk("sat_cnt", DATA_W'(cnt_o), 15);
        rdy_i = 1'b1; tick(); tick();
        chk("sat_hold", DATA_W'(cnt_o), 15);

        // Reset and flush together clear the counter
        rst = 1'b1; flush = 1'b1; tick();
        chk("rstfl_cnt", DATA_W'(cnt_o), 0);
        chk("rstfl_valid", DATA_W'(vld_o), 0);
        rst = 1'b0; flush = 1'b0;

        // Random handshake
        for (int i = 0; i < 10000; i++) begin
            vld_i   = 1'($urandom_range(0, 1));
            rdy_i   = ($urandom_range(0, 3) != 0) ? (i % 200 < 100) || ($urandom_range(0, 1) == 1) : 1'b0;
            flush   = ($urandom_range(0, 63) == 0);
            ctrl_i  = CTRL_W'($urandom);
            data_i  = {$urandom, $urandom, $urandom, $urandom};
            instr_i = $urandom;
            tick();
        end
        vld_i = 1'b0; flush = 1'b0; rdy_i = 1'b1;
        tick(); tick(); tick();
        chk("end_empty", DATA_W'(vld_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
